adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameters: none; two requesters and a 32-bit adder slice are fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-005 req_ready  out  2  per-requester accept; a request is taken when req_valid[i] & req_ready[i].
REQ-006 req_a0, req_b0, req_a1, req_b1  in  64 each  operands of requester 0 and 1.
REQ-007 req_wide  in  2  bit i = 1: 64-bit op (two passes); 0: 32-bit op on bits [31:0].
REQ-008 req_sub  in  2  bit i = 1: compute a - b; 0: a + b.
REQ-009 rsp_valid  out  2  one-hot response valid to the owning requester.
REQ-010 rsp_ready  in  2  per-requester response accept.
REQ-011 rsp_sum  out  64  result, shared by both requesters, qualified by rsp_valid.

Function
REQ-012 Single cla instance shared; at most one operation in flight; no pipelining between requests.
REQ-013 FSM states IDLE, LO, HI, RESP; IDLE->LO on accept; LO->HI if latched wide, else LO->RESP; HI->RESP; RESP->IDLE when rsp_ready of owner high.
REQ-014 req_ready nonzero only in IDLE, at most one bit set, combinationally from req_valid and priority pointer.
REQ-015 Round robin: pointer selects preferred requester when both valid; only one valid -> that one granted; after each accept pointer = ~(granted id).
REQ-016 Accept latches a, b, wide, sub, id; later changes on req_* inputs have no effect.
REQ-017 Subtract: adder b input = ~b slice, low-pass cin = 1; add: low-pass cin = 0.
REQ-018 LO pass: adder on bits [31:0]; sum registered into result[31:0] at end of LO.
REQ-019 Low carry-out registered at end of LO = majority(a[31], b'[31], s[31]^a[31]^b'[31]), b' = adder b input, s = LO sum.
REQ-020 HI pass: adder on bits [63:32], cin = registered carry; sum registered into result[63:32].
REQ-021 Narrow op: result[63:32] = 0; carry out of bit 63 / bit 31 discarded (wrap modulo 2^64 / 2^32).
REQ-022 Latency: narrow rsp_valid in 2nd cycle after accept cycle; wide in 3rd.
REQ-023 In RESP, rsp_valid[id] = 1 and rsp_sum stable until handshake; rsp_valid = 0 in all other states.
REQ-024 RESP handshake cycle: req_ready = 0 (new accept earliest the following cycle in IDLE).
REQ-025 rsp_ready of non-owner ignored; rsp_sum holds last result outside RESP.

Reset
REQ-026 rst: state = IDLE, pointer = 0, result = 0, carry = 0, rsp_valid = 0, req_ready reflects IDLE rules next cycle.
REQ-027 rst during LO/HI/RESP drops in-flight op; no response ever issued for it.
REQ-028 rst has priority over any simultaneous handshake.

Structure
REQ-029 Shared package holds state enum (IDLE, LO, HI, RESP) and constants SLICE_W = 32, OP_W = 64, NREQ = 2.
REQ-030 Exactly one sub-module: existing cla (32-bit), instantiated once, driven by muxed slice operands and cin.

Verification
REQ-031 Req0 narrow add 0x0000_0000_FFFF_FFFF + 1 -> rsp_valid=01 in cycle 2, rsp_sum=0x0.
REQ-032 Req1 wide add 0x0000_0000_FFFF_FFFF + 1 -> rsp_valid=10 in cycle 3, rsp_sum=0x0000_0001_0000_0000.
REQ-033 Req0 wide sub 0 - 1 -> rsp_sum=0xFFFF_FFFF_FFFF_FFFF; narrow sub 5 - 7 -> 0x0000_0000_FFFF_FFFE.
REQ-034 Both valid continuously after reset -> grants alternate 0,1,0,1; rsp_ready held low 5 cycles -> rsp_sum, rsp_valid stable, req_ready=00.
REQ-035 rst asserted during HI of wide op -> no rsp_valid, next cycle IDLE, pointer = 0, outputs 0.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
package adder_arbiter_pkg;

  localparam int unsigned SLICE_W = 32;
  localparam int unsigned OP_W    = 64;
  localparam int unsigned NREQ    = 2;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/adder_arbiter_cla.sv
// 32-bit carry-lookahead adder slice (sum only; carry-out derived by caller).
module cla
  import adder_arbiter_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum
);

  logic [SLICE_W-1:0] gen;
  logic [SLICE_W-1:0] prop;
  logic [SLICE_W-1:0] carry;

  // Generate/propagate terms and carry chain into each bit position.
  always_comb begin
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < SLICE_W - 1; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    sum = prop ^ carry;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder slice between two requesters;
// 64-bit operations take two passes (low then high slice).
module adder_arbiter
  import adder_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [OP_W-1:0]  req_a0,
  input  logic [OP_W-1:0]  req_b0,
  input  logic [OP_W-1:0]  req_a1,
  input  logic [OP_W-1:0]  req_b1,
  input  logic [NREQ-1:0]  req_wide,
  input  logic [NREQ-1:0]  req_sub,
  output logic [NREQ-1:0]  rsp_valid,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [OP_W-1:0]  rsp_sum
);

  state_t              state, next_state;
  logic                ptr;
  logic                grant_id;
  logic                accept;

  logic [OP_W-1:0]     op_a, op_b;
  logic                op_wide, op_sub, op_id;
  logic [OP_W-1:0]     result;
  logic                carry;

  logic [SLICE_W-1:0]  slice_a, slice_b, slice_b_raw, slice_sum;
  logic                slice_cin;
  logic                lo_cout;

  // Grant selection: only in IDLE, pointer breaks ties when both are valid.
  always_comb begin
    req_ready = '0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (req_valid == 2'b11) begin
        grant_id = ptr;
      end else begin
        grant_id = req_valid[1];
      end
      if (|req_valid) begin
        req_ready[grant_id] = 1'b1;
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  // Next-state decode for the two-pass add/sub sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LO;
      LO:      next_state = op_wide ? HI : RESP;
      HI:      next_state = RESP;
      RESP:    if (rsp_ready[op_id]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Slice operand mux: HI pass uses upper halves and the registered carry.
  always_comb begin
    slice_a     = (state == HI) ? op_a[OP_W-1:SLICE_W] : op_a[SLICE_W-1:0];
    slice_b_raw = (state == HI) ? op_b[OP_W-1:SLICE_W] : op_b[SLICE_W-1:0];
    slice_b     = op_sub ? ~slice_b_raw : slice_b_raw;
    slice_cin   = (state == HI) ? carry : op_sub;
    lo_cout     = maj3(slice_a[SLICE_W-1], slice_b[SLICE_W-1],
                       slice_sum[SLICE_W-1] ^ slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1]);
  end

  cla u_cla (
    .a   (slice_a),
    .b   (slice_b),
    .cin (slice_cin),
    .sum (slice_sum)
  );

  // State, pointer, latched operands and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_wide <= 1'b0;
      op_sub  <= 1'b0;
      op_id   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        ptr     <= ~grant_id;
        op_a    <= grant_id ? req_a1 : req_a0;
        op_b    <= grant_id ? req_b1 : req_b0;
        op_wide <= req_wide[grant_id];
        op_sub  <= req_sub[grant_id];
        op_id   <= grant_id;
      end
      if (state == LO) begin
        result[SLICE_W-1:0] <= slice_sum;
        carry               <= lo_cout;
        if (!op_wide) begin
          result[OP_W-1:SLICE_W] <= '0;
        end
      end
      if (state == HI) begin
        result[OP_W-1:SLICE_W] <= slice_sum;
      end
    end
  end

  assign rsp_valid = (state == RESP) ? (op_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_sum   = result;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter against an arithmetic reference model.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_wide, req_sub;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [63:0] rsp_sum;

  int n_checks = 0;
  int n_fail   = 0;
  bit tb_ptr   = 1'b0;

  adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_wide  (req_wide),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input bit wide, input bit sub);
    logic [31:0] n;
    if (wide) return sub ? a - b : a + b;
    n = sub ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
    return {32'h0, n};
  endfunction

  function automatic logic [1:0] onehot(input bit id);
    return id ? 2'b10 : 2'b01;
  endfunction

  task automatic scramble();
    req_a0   = {$urandom, $urandom};
    req_b0   = {$urandom, $urandom};
    req_a1   = {$urandom, $urandom};
    req_b1   = {$urandom, $urandom};
    req_wide = 2'($urandom);
    req_sub  = 2'($urandom);
  endtask

  // Issue one request from a single requester; returns observed grant,
  // response cycle index (accept cycle = 0), response valid and sum.
  task automatic do_op(input bit id, input logic [63:0] a, input logic [63:0] b,
                       input bit wide, input bit sub,
                       output logic [1:0] rdy, output int lat,
                       output logic [1:0] vld, output logic [63:0] sum);
    bit granted = 0;
    bit got = 0;
    rsp_ready = 2'b11;
    req_valid = '0;
    req_valid[id] = 1'b1;
    if (id) begin req_a1 = a; req_b1 = b; end
    else    begin req_a0 = a; req_b0 = b; end
    req_wide[id] = wide;
    req_sub[id]  = sub;
    rdy = '0; vld = '0; sum = '0; lat = -1;
    for (int k = 0; k < 10 && !granted; k++) begin
      #1;
      if (req_ready !== 2'b00) granted = 1;
      else @(negedge clk);
    end
    rdy = req_ready;
    if (!granted) begin
      req_valid = '0;
      return;
    end
    @(posedge clk);
    tb_ptr = ~id;
    lat = 1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = '0;
        scramble();
      end
      if (rsp_valid !== 2'b00) begin
        got = 1;
        vld = rsp_valid;
        sum = rsp_sum;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_wide = '0; req_sub = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 00", rsp_valid); end
    n_checks++;
    if (rsp_sum !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_sum: got %h required 0", rsp_sum); end
    rst = 1'b0;
    tb_ptr = 0;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready_idle: got %b required 00", req_ready); end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_ptr_both: got %b required 01", req_ready); end
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL reset_single_req1: got %b required 10", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_directed();
    logic [63:0] va[4], vb[4], sum, exp;
    bit vid[4], vw[4], vs[4];
    logic [1:0] rdy, vld;
    int lat, exp_lat;
    va[0] = 64'h0000_0000_FFFF_FFFF; vb[0] = 64'd1; vid[0] = 0; vw[0] = 0; vs[0] = 0;
    va[1] = 64'h0000_0000_FFFF_FFFF; vb[1] = 64'd1; vid[1] = 1; vw[1] = 1; vs[1] = 0;
    va[2] = 64'd0;                   vb[2] = 64'd1; vid[2] = 0; vw[2] = 1; vs[2] = 1;
    va[3] = 64'd5;                   vb[3] = 64'd7; vid[3] = 0; vw[3] = 0; vs[3] = 1;
    for (int i = 0; i < 4; i++) begin
      exp = (i == 0) ? 64'h0 : (i == 1) ? 64'h0000_0001_0000_0000 :
            (i == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFE;
      exp_lat = vw[i] ? 3 : 2;
      do_op(vid[i], va[i], vb[i], vw[i], vs[i], rdy, lat, vld, sum);
      n_checks++;
      if (rdy !== onehot(vid[i])) begin n_fail++; $display("FAIL dir%0d_grant: got %b required %b", i, rdy, onehot(vid[i])); end
      n_checks++;
      if (lat != exp_lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, exp_lat); end
      n_checks++;
      if (vld !== onehot(vid[i])) begin n_fail++; $display("FAIL dir%0d_rsp_valid: got %b required %b", i, vld, onehot(vid[i])); end
      n_checks++;
      if (sum !== exp) begin n_fail++; $display("FAIL dir%0d_sum: got %h required %h", i, sum, exp); end
    end
  endtask

  task automatic test_round_robin_stall();
    logic [63:0] exp;
    bit exp_id, got;
    int lat;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_ptr = 0;
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_id = bit'(g % 2);
      scramble();
      exp = exp_id ? model(req_a1, req_b1, req_wide[1], req_sub[1])
                   : model(req_a0, req_b0, req_wide[0], req_sub[0]);
      #1;
      n_checks++;
      if (req_ready !== onehot(exp_id)) begin n_fail++; $display("FAIL rr%0d_grant: got %b required %b", g, req_ready, onehot(exp_id)); end
      @(posedge clk);
      tb_ptr = ~exp_id;
      lat = 1;
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (k == 0) scramble();
        if (rsp_valid !== 2'b00) got = 1;
        else begin @(posedge clk); lat++; end
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL rr%0d_timeout: got no rsp_valid required %b", g, onehot(exp_id)); end
      n_checks++;
      if (rsp_valid !== onehot(exp_id)) begin n_fail++; $display("FAIL rr%0d_rsp_valid: got %b required %b", g, rsp_valid, onehot(exp_id)); end
      if (g == 0) begin
        rsp_ready = ~onehot(exp_id);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_checks++;
          if (rsp_valid !== onehot(exp_id) || rsp_sum !== exp || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_stall%0d: got valid=%b sum=%h ready=%b required valid=%b sum=%h ready=00",
                     s, rsp_valid, rsp_sum, req_ready, onehot(exp_id), exp);
          end
        end
      end
      rsp_ready = onehot(exp_id);
      #1;
      n_checks++;
      if (rsp_sum !== exp) begin n_fail++; $display("FAIL rr%0d_sum: got %h required %h", g, rsp_sum, exp); end
      n_checks++;
      if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr%0d_ready_in_handshake: got %b required 00", g, req_ready); end
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_midop();
    req_valid = 2'b01;
    req_a0 = {$urandom, $urandom};
    req_b0 = {$urandom, $urandom};
    req_wide = 2'b01;
    req_sub = 2'b00;
    rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_grant: got %b required 01", req_ready); end
    @(posedge clk);
    tb_ptr = 1;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_ptr = 0;
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b required 00", rsp_valid); end
    n_checks++;
    if (rsp_sum !== 64'h0) begin n_fail++; $display("FAIL midrst_rsp_sum: got %h required 0", rsp_sum); end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_ptr: got %b required 01", req_ready); end
    req_valid = 2'b00;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_no_rsp%0d: got %b required 00", s, rsp_valid); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, sum, exp;
    logic [1:0] rdy, vld;
    bit id, wide, sub;
    int lat;
    for (int i = 0; i < 30; i++) begin
      id   = 1'($urandom);
      wide = 1'($urandom);
      sub  = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 7 == 0) a = '1;
      if (i % 5 == 0) b = {32'h0, 32'hFFFF_FFFF};
      exp = model(a, b, wide, sub);
      do_op(id, a, b, wide, sub, rdy, lat, vld, sum);
      n_checks++;
      if (rdy !== onehot(id)) begin n_fail++; $display("FAIL rnd%0d_grant: got %b required %b", i, rdy, onehot(id)); end
      n_checks++;
      if (lat != (wide ? 3 : 2)) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d required %0d", i, lat, wide ? 3 : 2); end
      n_checks++;
      if (vld !== onehot(id)) begin n_fail++; $display("FAIL rnd%0d_rsp_valid: got %b required %b", i, vld, onehot(id)); end
      n_checks++;
      if (sum !== exp) begin n_fail++; $display("FAIL rnd%0d_sum: got %h required %h (a=%h b=%h w=%0d s=%0d)", i, sum, exp, a, b, wide, sub); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin_stall();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
